// File: rtl/simon_pkt_rx.sv
// Byte-serial packet assembler feeding SIMON_dataIN: gathers N/2+2 bytes into an
// assembly buffer and double-buffers them onto `in`, dropping stalled partial packets.
module simon_pkt_rx #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int TO = 255
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic [7:0]           byteIN,
    input  logic                 byteValid,
    output logic                 byteReady,
    output logic [N/2+1:0][7:0]  in,
    output logic                 newIN,
    input  logic                 loadPkt,
    output logic                 rxErr
);

    localparam int P  = N / 2 + 2;
    localparam int CW = $clog2(P + 1);

    // Reject parameter sets the counters cannot represent; M only mirrors SIMON_dataIN.
    if (N < 2 || M < 1 || TO < 1 || TO > 65535) begin : g_bad_params
        $error("simon_pkt_rx: illegal parameters");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        FULL     = 2'd2
    } state_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [15:0]            tcnt_q;
    logic [P-1:0][7:0]      abuf_q;
    logic [P-1:0][7:0]      in_q;
    logic                   new_q;
    logic                   err_q;

    logic                   accept_s;
    logic [CW-1:0]          widx_s;

    assign byteReady = (state_q != FULL);
    assign accept_s  = byteValid && byteReady;
    // First byte lands in the top slot so in[P-1] is the info byte.
    assign widx_s    = CW'(P - 1) - cnt_q;

    assign in    = in_q;
    assign newIN = new_q;
    assign rxErr = err_q;

    // Assembly FSM, inter-byte timeout and output hold register.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tcnt_q  <= 16'd0;
            abuf_q  <= '0;
            in_q    <= '0;
            new_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (new_q && loadPkt) begin
                new_q <= 1'b0;
            end else begin
                new_q <= new_q;
            end

            case (state_q)
                IDLE: begin
                    tcnt_q <= 16'd0;
                    if (accept_s) begin
                        abuf_q[widx_s] <= byteIN;
                        cnt_q          <= CW'(1);
                        state_q        <= ASSEMBLE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                ASSEMBLE: begin
                    if (accept_s) begin
                        abuf_q[widx_s] <= byteIN;
                        tcnt_q         <= 16'd0;
                        if (cnt_q == CW'(P - 1)) begin
                            cnt_q   <= '0;
                            state_q <= FULL;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                            state_q <= ASSEMBLE;
                        end
                    end else if (tcnt_q == 16'(TO - 1)) begin
                        cnt_q   <= '0;
                        tcnt_q  <= 16'd0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tcnt_q  <= tcnt_q + 16'd1;
                        state_q <= ASSEMBLE;
                    end
                end
                FULL: begin
                    tcnt_q <= 16'd0;
                    // Registered newIN gates the hand-over, guaranteeing a low cycle between packets.
                    if (!new_q) begin
                        in_q    <= abuf_q;
                        new_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        state_q <= FULL;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    tcnt_q  <= 16'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_pkt_rx.sv
// Self-checking bench for simon_pkt_rx: scoreboard of expected packets popped on each newIN rise.
module tb_simon_pkt_rx;

    localparam int N  = 16;
    localparam int P  = N / 2 + 2;
    localparam int TO = 8;

    logic                clk;
    logic                R;
    logic [7:0]          byteIN;
    logic                byteValid;
    logic                byteReady;
    logic [P-1:0][7:0]   in;
    logic                newIN;
    logic                loadPkt;
    logic                rxErr;

    int n_chk  = 0;
    int n_pass = 0;
    int rxerr_cnt = 0;
    logic prev_new = 1'b0;
    logic [P*8-1:0] exp_q[$];

    simon_pkt_rx #(.N(N), .M(4), .TO(TO)) dut (
        .clk       (clk),
        .R         (R),
        .byteIN    (byteIN),
        .byteValid (byteValid),
        .byteReady (byteReady),
        .in        (in),
        .newIN     (newIN),
        .loadPkt   (loadPkt),
        .rxErr     (rxErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [P*8-1:0] obs, input logic [P*8-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: every fresh newIN rise must present the oldest outstanding packet.
    always @(negedge clk) begin
        if (rxErr) rxerr_cnt++;
        if (newIN && !prev_new) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pkt", 80'd1, 80'd0);
            end else begin
                chk("sb_pkt", in, exp_q.pop_front());
            end
        end
        prev_new <= newIN;
    end

    task automatic send_byte(input logic [7:0] b);
        int i;
        byteIN    = b;
        byteValid = 1'b1;
        i = 0;
        while (!byteReady && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!byteReady) chk("accept_timeout", 80'd0, 80'd1);
        @(posedge clk);
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic send_pkt(input logic [P*8-1:0] v, input int nbytes);
        for (int i = P - 1; i >= P - nbytes; i--) begin
            send_byte(v[i*8 +: 8]);
        end
        if (nbytes == P) exp_q.push_back(v);
    endtask

    task automatic wait_new(input string tag);
        int i;
        i = 0;
        while (!newIN && i < 30) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {79'd0, newIN}, 80'd1);
    endtask

    task automatic ack();
        loadPkt = 1'b1;
        @(negedge clk);
        loadPkt = 1'b0;
    endtask

    function automatic logic [P*8-1:0] rnd_pkt();
        logic [P*8-1:0] v;
        for (int i = 0; i < P; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    logic [P*8-1:0] pkt1, pa, pb, pc;
    int first_err;
    logic ready_ok;
    int err_base;

    initial begin
        R = 1'b1; byteIN = 8'hAA; byteValid = 1'b1; loadPkt = 1'b0;
        pkt1 = 80'h80006565687721403F21;
        repeat (3) @(negedge clk);
        chk("rst_in", in, 80'd0);
        chk("rst_newIN", {79'd0, newIN}, 80'd0);
        chk("rst_rxErr", {79'd0, rxErr}, 80'd0);
        chk("rst_byteReady", {79'd0, byteReady}, 80'd1);
        R = 1'b0; byteValid = 1'b0;
        @(negedge clk);

        // Single packet, latency and ack
        send_pkt(pkt1, P);
        chk("last_byte_ready", {79'd0, byteReady}, 80'd0);
        chk("last_byte_new", {79'd0, newIN}, 80'd0);
        @(negedge clk);
        chk("present_new", {79'd0, newIN}, 80'd1);
        chk("present_ready", {79'd0, byteReady}, 80'd1);
        ack();
        chk("ack_new", {79'd0, newIN}, 80'd0);
        chk("ack_in_hold", in, pkt1);

        // Backpressure: A held, B fills the assembly buffer
        pa = rnd_pkt(); pb = rnd_pkt();
        send_pkt(pa, P);
        @(negedge clk);
        send_pkt(pb, P);
        chk("bp_ready", {79'd0, byteReady}, 80'd0);
        chk("bp_in_a", in, pa);
        repeat (2) @(negedge clk);
        chk("bp_ready_hold", {79'd0, byteReady}, 80'd0);
        ack();
        chk("bp_gap_new", {79'd0, newIN}, 80'd0);
        chk("bp_gap_ready", {79'd0, byteReady}, 80'd0);
        @(negedge clk);
        chk("bp_b_new", {79'd0, newIN}, 80'd1);
        chk("bp_b_ready", {79'd0, byteReady}, 80'd1);
        ack();

        // Timeout after 3 bytes
        err_base = rxerr_cnt;
        pc = rnd_pkt();
        send_pkt(pc, 3);
        first_err = 0;
        ready_ok = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rxErr && first_err == 0) first_err = c;
            if (!byteReady) ready_ok = 1'b0;
        end
        chk("to_latency", 80'(first_err), 80'd8);
        chk("to_pulse_count", 80'(rxerr_cnt - err_base), 80'd1);
        chk("to_ready", {79'd0, ready_ok}, 80'd1);
        pc = rnd_pkt();
        pc[P*8-1 -: 8] = 8'hC5;
        send_pkt(pc, P);
        wait_new("to_next_pkt");
        chk("to_info_byte", {72'd0, in[P-1]}, {72'd0, 8'hC5});
        ack();

        // Timeout race: byte accepted on the cycle tcnt == TO-1
        err_base = rxerr_cnt;
        pc = rnd_pkt();
        send_pkt(pc, 3);
        repeat (TO - 1) @(negedge clk);
        send_byte(pc[(P-4)*8 +: 8]);
        for (int i = P - 5; i >= 0; i--) send_byte(pc[i*8 +: 8]);
        exp_q.push_back(pc);
        wait_new("race_pkt");
        chk("race_no_err", 80'(rxerr_cnt - err_base), 80'd0);
        ack();

        // Reset mid-op: A held, 5 bytes of B in flight
        pa = rnd_pkt(); pb = rnd_pkt();
        send_pkt(pa, P);
        wait_new("rst_hold_a");
        err_base = rxerr_cnt;
        send_pkt(pb, 5);
        #2 R = 1'b1;
        #1;
        chk("midrst_new", {79'd0, newIN}, 80'd0);
        chk("midrst_in", in, 80'd0);
        @(negedge clk);
        R = 1'b0;
        @(negedge clk);
        chk("midrst_no_err", 80'(rxerr_cnt - err_base), 80'd0);
        pc = rnd_pkt();
        send_pkt(pc, P);
        wait_new("midrst_fresh");
        ack();

        // Spurious ack while nothing is held
        ack();
        chk("spur_new", {79'd0, newIN}, 80'd0);
        chk("spur_ready", {79'd0, byteReady}, 80'd1);
        repeat (3) @(negedge clk);
        pc = rnd_pkt();
        send_pkt(pc, P);
        wait_new("spur_pkt");
        ack();

        repeat (3) @(negedge clk);
        chk("sb_empty", 80'(exp_q.size()), 80'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/simon_pkt_rx.md
# simon_pkt_rx

Byte-serial packet assembler sitting directly upstream of `SIMON_dataIN`. Accepts one byte per handshake from the link front end, gathers `N/2+2` bytes (info byte, then key/data payload) into an assembly buffer, and presents the completed packet on `in` with `newIN` held high until `SIMON_dataIN` acknowledges it with `loadPkt`. It double-buffers, so the next packet can stream in while the previous one waits, and it discards partial packets after an inter-byte timeout.

## Interface
- `N`, 16: SIMON word width. Packet length `P = N/2+2` bytes (10 at default).
- `M`, 4: key words. Carried for parameter compatibility with `SIMON_dataIN`; unused.
- `TO`, 255: inter-byte timeout in clock cycles. Range 1..65535.
- `clk`  in  1: sole clock, rising-edge.
- `R`  in  1: asynchronous, active-high reset.
- `byteIN`  in  8: received byte.
- `byteValid`  in  1: `byteIN` valid this cycle.
- `byteReady`  out  1: block can accept a byte. Transfer occurs when `byteValid && byteReady` at a rising edge.
- `in`  out  `[P-1:0][7:0]`: presented packet. `in[P-1]` is the first byte received (the info byte).
- `newIN`  out  1: `in` holds an unconsumed packet.
- `loadPkt`  in  1: `SIMON_dataIN` has captured `in`.
- `rxErr`  out  1: one-cycle pulse when a partial packet is dropped on timeout.

## Operation
- Assembly FSM states:
  - IDLE: `cnt = 0`.
  - ASSEMBLE: `0 < cnt < P`.
  - FULL: assembly buffer complete, waiting for the output stage.
- `byteReady = (state != FULL)`. Combinational from state only.
- Accepted byte is written to `abuf[P-1-cnt]`, then `cnt++`.
  - IDLE→ASSEMBLE on the first byte.
  - Accepting byte number `P` goes to FULL and sets `cnt = 0`.
  - `P = 1` cannot occur (`N ≥ 2`).
- FULL with `newIN == 0`: at the next edge, `in <= abuf`, `newIN <= 1`, state→IDLE.
- FULL with `newIN == 1`: stay in FULL with `byteReady = 0`.
- Output stage:
  - `newIN && loadPkt` at an edge clears `newIN`.
  - `in` holds its value and is not cleared.
  - `loadPkt` while `newIN == 0` is ignored.
- Transfer condition samples the registered `newIN`. When `loadPkt` clears `newIN` in the same cycle the FSM is in FULL, the transfer happens one edge later. Consequence: `newIN` is always low for at least one cycle between packets, so `SIMON_dataIN` sees a fresh rising edge.
- Timeout:
  - Idle counter `tcnt`, 16 bits.
  - In ASSEMBLE, `tcnt` increments on every cycle with no accepted byte. It clears on any accepted byte and in all other states.
  - When `tcnt == TO-1` and no byte is accepted: `cnt <= 0`, state→IDLE, `rxErr <= 1` for one cycle.
  - A byte accepted on the expiring cycle wins: it is stored and no error is raised.
- Bytes are never dropped once accepted, except by timeout or reset.

## Timing
- Reset values: `in = 0`, `newIN = 0`, `rxErr = 0`, state IDLE, `cnt = 0`, `tcnt = 0`. `byteReady` is therefore 1 during reset.
- `R` dominates. Bytes presented while `R = 1` are not stored.
- Reset mid-packet or mid-hold discards everything. No `rxErr` pulse.
- Latency: last byte accepted at edge k → `byteReady = 0` during cycle k..k+1 → `in`/`newIN` valid after edge k+1 (output free case). `byteReady` returns to 1 after edge k+1.
- Minimum packet period is `P+1` cycles, one bubble cycle per packet.
- `loadPkt` is sampled at each edge. Asserted at edge j, `newIN` is low after edge j.
- `rxErr` rises after the edge at which the timeout fires and falls after the following edge.

## Test plan
- Single packet: reset, then send 0x80,0x00,0x65,0x65,0x68,0x77,0x21,0x40,0x3F,0x21 back-to-back. Expect `in = 80'h80006565687721403F21` and `newIN = 1` one edge after the last byte. Pulse `loadPkt` one cycle. Expect `newIN = 0` next edge and `in` unchanged.
- Backpressure: send packet A, do not assert `loadPkt`, then send 10 bytes of packet B. Expect `byteReady = 0` after B's 10th byte. Assert `loadPkt`. Expect `newIN` low exactly one cycle, then `in = B`, `newIN = 1`, `byteReady = 1`.
- Timeout: `TO = 8`. Send 3 bytes, then idle. Expect `rxErr` pulse 8 cycles after the 3rd byte and `byteReady` remaining 1. A following full packet assembles correctly with its first byte at `in[9]`.
- Timeout race: `TO = 8`. Send a byte exactly on the cycle `tcnt == 7`. Expect no `rxErr`, and `cnt` advances.
- Reset mid-op: assert `R` asynchronously mid-clock after 5 bytes of packet B while packet A is held. Expect `newIN = 0` and `in = 0` immediately. After release, a fresh 10-byte packet presents correctly.
- Spurious ack: `loadPkt = 1` while `newIN = 0`. Expect no state change. Then a packet delivered 3 cycles later still raises `newIN`.
